uart_baud_gen: RTL and testbench

Parametrised baud-rate timing generator for the FPGA UART path. One shared oversample counter with a runtime-loadable divisor drives three timing outputs: a free-running TX bit strobe, a 50 % baud square wave for legacy consumers, and an RX mid-bit sample strobe that can be re-phased on each detected start edge. It replaces the fixed 651-count divider and feeds the UART transmitter and receiver that carry MNIST image bytes in and results out.

---
 rtl/uart_baud_gen.sv | 137 +++++++++++++
 tb/tb_uart_baud_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Baud-rate timing generator: one oversample counter with a runtime divisor
// drives the TX bit strobe, a 50 % baud square wave and a re-phasable RX mid-bit strobe.
module uart_baud_gen #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 651
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             rx_resync,
    output logic             os_tick,
    output logic             tx_tick,
    output logic             rx_mid_tick,
    output logic             baud_clk,
    output logic             div_err
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] OS_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] OS_HALF = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] OS_PRE  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic CFG_OK = (CLK_HZ > 0) && (OVERSAMPLE >= 4) &&
                              (OVERSAMPLE % 2 == 0) && (DEFAULT_DIV >= 2);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_os_cnt;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic             r_os_tick;
    logic             r_tx_tick;
    logic             r_rx_mid;
    logic             r_baud;
    logic             r_err;

    logic             w_load_ok;
    logic             w_os_evt;
    logic             w_tx_wrap;
    logic [CNT_W-1:0] w_tx_inc;
    logic [CNT_W-1:0] w_rx_inc;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_os_cnt_nxt;
    logic [CNT_W-1:0] w_tx_cnt_nxt;
    logic [CNT_W-1:0] w_rx_cnt_nxt;
    logic             w_os_tick_nxt;
    logic             w_tx_tick_nxt;
    logic             w_rx_mid_nxt;
    logic             w_baud_nxt;
    logic             w_err_nxt;

    assign w_load_ok = div_load && (div_in >= DIV_MIN);
    assign w_os_evt  = en && (r_os_cnt == (r_div - DIV_W'(1)));
    assign w_tx_wrap = (r_tx_cnt == OS_LAST);
    assign w_tx_inc  = w_tx_wrap ? '0 : r_tx_cnt + CNT_W'(1);
    assign w_rx_inc  = (r_rx_cnt == OS_LAST) ? '0 : r_rx_cnt + CNT_W'(1);

    always_comb begin
        w_div_nxt     = r_div;
        w_os_cnt_nxt  = r_os_cnt;
        w_tx_cnt_nxt  = r_tx_cnt;
        w_rx_cnt_nxt  = r_rx_cnt;
        w_os_tick_nxt = 1'b0;
        w_tx_tick_nxt = 1'b0;
        w_rx_mid_nxt  = 1'b0;
        w_baud_nxt    = r_baud;
        w_err_nxt     = r_err;
        if (w_load_ok) begin
            w_div_nxt    = div_in;
            w_os_cnt_nxt = '0;
            w_tx_cnt_nxt = '0;
            w_rx_cnt_nxt = '0;
            w_baud_nxt   = 1'b1;
        end else begin
            // An illegal load is only recorded; counting and resync carry on.
            if (div_load) begin
                w_err_nxt = 1'b1;
            end
            if (w_os_evt) begin
                w_os_cnt_nxt  = '0;
                w_os_tick_nxt = 1'b1;
                w_tx_cnt_nxt  = w_tx_inc;
                w_tx_tick_nxt = w_tx_wrap;
                w_baud_nxt    = (w_tx_inc < OS_HALF);
                w_rx_cnt_nxt  = w_rx_inc;
                w_rx_mid_nxt  = (r_rx_cnt == OS_PRE);
            end else if (en) begin
                w_os_cnt_nxt = r_os_cnt + DIV_W'(1);
            end
            if (rx_resync) begin
                w_rx_cnt_nxt = '0;
                w_rx_mid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= DIV_RST;
            r_os_cnt  <= '0;
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_os_tick <= 1'b0;
            r_tx_tick <= 1'b0;
            r_rx_mid  <= 1'b0;
            r_baud    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_os_cnt  <= w_os_cnt_nxt;
            r_tx_cnt  <= w_tx_cnt_nxt;
            r_rx_cnt  <= w_rx_cnt_nxt;
            r_os_tick <= w_os_tick_nxt;
            r_tx_tick <= w_tx_tick_nxt;
            r_rx_mid  <= w_rx_mid_nxt;
            r_baud    <= w_baud_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (CFG_OK);
        end
    end

    assign os_tick     = r_os_tick;
    assign tx_tick     = r_tx_tick;
    assign rx_mid_tick = r_rx_mid;
    assign baud_clk    = r_baud;
    assign div_err     = r_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: per-cycle expected tick/baud levels from
// hand-derived closed forms, summarised per segment.
module tb_uart_baud_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] div_in;
    logic        div_load;
    logic        rx_resync;
    logic        os_tick;
    logic        tx_tick;
    logic        rx_mid_tick;
    logic        baud_clk;
    logic        div_err;

    int checks   = 0;
    int failures = 0;
    int e_os, e_tx, e_rx, e_bd;
    int n_os, n_tx, n_rx;

    uart_baud_gen #(
        .CLK_HZ     (100_000_000),
        .OVERSAMPLE (16),
        .DIV_W      (16),
        .DEFAULT_DIV(651)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_in     (div_in),
        .div_load   (div_load),
        .rx_resync  (rx_resync),
        .os_tick    (os_tick),
        .tx_tick    (tx_tick),
        .rx_mid_tick(rx_mid_tick),
        .baud_clk   (baud_clk),
        .div_err    (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        e_os = 0; e_tx = 0; e_rx = 0; e_bd = 0;
        n_os = 0; n_tx = 0; n_rx = 0;
    endtask

    task automatic sample(input logic eos, input logic etx, input logic erx, input logic ebd);
        if (os_tick !== eos) e_os++;
        if (tx_tick !== etx) e_tx++;
        if (rx_mid_tick !== erx) e_rx++;
        if (baud_clk !== ebd) e_bd++;
        if (os_tick === 1'b1) n_os++;
        if (tx_tick === 1'b1) n_tx++;
        if (rx_mid_tick === 1'b1) n_rx++;
    endtask

    task automatic report(input string tag, input int xos, input int xtx, input int xrx);
        chk({tag, "_os_pos_errs"}, e_os, 0);
        chk({tag, "_tx_pos_errs"}, e_tx, 0);
        chk({tag, "_rx_pos_errs"}, e_rx, 0);
        chk({tag, "_baud_errs"}, e_bd, 0);
        chk({tag, "_os_count"}, n_os, xos);
        chk({tag, "_tx_count"}, n_tx, xtx);
        chk({tag, "_rx_count"}, n_rx, xrx);
    endtask

    initial begin
        int jj;
        reset = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0; rx_resync = 1'b0;
        clr();

        // Reset state
        repeat (3) step();
        chk("rst_os", os_tick, 0);
        chk("rst_tx", tx_tick, 0);
        chk("rst_rx", rx_mid_tick, 0);
        chk("rst_baud", baud_clk, 1);
        chk("rst_err", div_err, 0);

        // Default divisor 651: os every 651, bit 10416, baud low from os event 8
        reset = 1'b0; en = 1'b1;
        for (int k = 1; k <= 36455; k++) begin
            step();
            sample((k % 651) == 0, (k % 10416) == 0, (k % 10416) == 5208,
                   (k % 10416) < 5208);
        end
        report("A", 55, 3, 3);

        // Load div 4 exactly on what would be os event 8: no ticks, baud forced high
        clr();
        div_load = 1'b1; div_in = 16'd4;
        step();
        div_load = 1'b0;
        chk("B_load_os", os_tick, 0);
        chk("B_load_tx", tx_tick, 0);
        chk("B_load_rx", rx_mid_tick, 0);
        chk("B_load_baud", baud_clk, 1);

        // Div 4, with illegal loads of 1 and 0 at j=129/130 that must not disturb it
        for (int j = 1; j <= 192; j++) begin
            if (j == 129) begin div_load = 1'b1; div_in = 16'd1; end
            if (j == 130) begin div_load = 1'b1; div_in = 16'd0; end
            if (j == 131) div_load = 1'b0;
            step();
            sample((j % 4) == 0, (j % 64) == 0, (j % 64) == 32, (j % 64) < 32);
            if (j == 129) chk("C_err_after_div1", div_err, 1);
        end
        report("B", 48, 3, 3);
        chk("C_err_sticky", div_err, 1);

        // Legal load of div 10; div_err stays set
        clr();
        div_load = 1'b1; div_in = 16'd10;
        step();
        div_load = 1'b0;
        chk("C_err_after_legal", div_err, 1);
        chk("C_load_os", os_tick, 0);

        // Div 10: resync at j=23 and on the os event at j=420; en low for j=565..601
        for (int j = 1; j <= 737; j++) begin
            rx_resync = (j == 23) || (j == 420);
            en = !((j >= 565) && (j <= 601));
            step();
            if (j >= 565 && j <= 601) begin
                sample(0, 0, 0, 0);
            end else begin
                jj = (j > 601) ? j - 37 : j;
                sample((jj % 10) == 0, (jj % 160) == 0,
                       (jj == 100) || (jj == 260) || (jj == 500) || (jj == 660),
                       (jj % 160) < 80);
            end
            if (j == 420) chk("D_coinc_os", os_tick, 1);
            if (j == 420) chk("D_coinc_rx", rx_mid_tick, 0);
        end
        rx_resync = 1'b0; en = 1'b1;
        report("D", 70, 4, 4);

        // Reset together with a div_load: reset wins, divisor back to 651
        clr();
        reset = 1'b1; div_load = 1'b1; div_in = 16'd4;
        step();
        chk("F_rst_os", os_tick, 0);
        chk("F_rst_tx", tx_tick, 0);
        chk("F_rst_rx", rx_mid_tick, 0);
        chk("F_rst_baud", baud_clk, 1);
        chk("F_rst_err", div_err, 0);
        reset = 1'b0; div_load = 1'b0;
        for (int k = 1; k <= 1302; k++) begin
            step();
            sample((k % 651) == 0, 0, 0, 1);
        end
        report("F", 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
